// File: rtl/fmaseqnormshift.sv
// Iterative FMA normalization left shifter: shifts by at most STEP bits per cycle, with a tag carried alongside.
// Define FMA_NORM_BARREL_EN to apply the whole shift in one barrel stage. The format is given by NF/NE.
module fmaseqnormshift #(
    parameter int NF   = 52,
    parameter int NE   = 11,
    parameter int STEP = 16,
    localparam int W   = 3*NF+6,
    localparam int SW  = $clog2(3*NF+5),
    localparam int TW  = NE+2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          Flush,
    input  logic          InValid,
    output logic          InReady,
    input  logic [W-1:0]  ShiftIn,
    input  logic [SW-1:0] ShiftAmt,
    input  logic [TW-1:0] NormSumExpIn,
    output logic          OutValid,
    input  logic          OutReady,
    output logic [W-1:0]  Shifted,
    output logic [TW-1:0] NormSumExpOut,
    output logic          Busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // STEP can equal 2**SW, so compare against it one bit wider than Rem.
    localparam logic [SW:0] STEP_C = (SW+1)'(STEP);

    state_t        state_reg, state_next;
    logic [W-1:0]  data_reg, data_next;
    logic [SW-1:0] rem_reg, rem_next;
    logic [TW-1:0] tag_reg, tag_next;
    logic [SW-1:0] step;
    logic          last_step;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            data_reg  <= '0;
            rem_reg   <= '0;
            tag_reg   <= '0;
        end else begin
            state_reg <= state_next;
            data_reg  <= data_next;
            rem_reg   <= rem_next;
            tag_reg   <= tag_next;
        end
    end

    // The step is never larger than Rem, so Rem counts down to exactly zero without wrapping.
    always_comb begin
        last_step = ({1'b0, rem_reg} <= STEP_C);
        step      = last_step ? rem_reg : STEP_C[SW-1:0];
    end

    always_comb begin
        state_next = state_reg;
        data_next  = data_reg;
        rem_next   = rem_reg;
        tag_next   = tag_reg;
        case (state_reg)
            IDLE: begin
                if (InValid) begin
                    tag_next = NormSumExpIn;
`ifdef FMA_NORM_BARREL_EN
                    data_next  = ShiftIn << ShiftAmt;
                    rem_next   = '0;
                    state_next = DONE;
`else
                    data_next  = ShiftIn;
                    rem_next   = ShiftAmt;
                    state_next = (ShiftAmt == '0) ? DONE : SHIFT;
`endif
                end
            end
            SHIFT: begin
                data_next = data_reg << step;
                rem_next  = rem_reg - step;
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (OutReady) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        // An abort wins over any handshake seen in the same cycle.
        if (Flush) begin
            state_next = IDLE;
        end
    end

    // Outputs decode state only; the result is exposed only while it is valid.
    always_comb begin
        InReady       = (state_reg == IDLE);
        OutValid      = (state_reg == DONE);
        Busy          = (state_reg != IDLE);
        Shifted       = (state_reg == DONE) ? data_reg : '0;
        NormSumExpOut = (state_reg == DONE) ? tag_reg  : '0;
    end

endmodule

// File: tb/tb_fmaseqnormshift.sv
// Bench for fmaseqnormshift: directed cases with literal results and latencies, then random traffic
// compared every cycle against a transaction-level model (result = ShiftIn << ShiftAmt, latency from STEP).
module tb_fmaseqnormshift;
    localparam int NF   = 52;
    localparam int NE   = 11;
    localparam int STEP = 16;
    localparam int W    = 3*NF+6;
    localparam int SW   = $clog2(3*NF+5);
    localparam int TW   = NE+2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          Flush = 1'b0;
    logic          InValid = 1'b0;
    logic          InReady;
    logic [W-1:0]  ShiftIn = '0;
    logic [SW-1:0] ShiftAmt = '0;
    logic [TW-1:0] NormSumExpIn = '0;
    logic          OutValid;
    logic          OutReady = 1'b0;
    logic [W-1:0]  Shifted;
    logic [TW-1:0] NormSumExpOut;
    logic          Busy;

    always #5 clk = ~clk;

    fmaseqnormshift #(.NF(NF), .NE(NE), .STEP(STEP)) dut (
        .clk(clk), .reset(reset), .Flush(Flush),
        .InValid(InValid), .InReady(InReady),
        .ShiftIn(ShiftIn), .ShiftAmt(ShiftAmt), .NormSumExpIn(NormSumExpIn),
        .OutValid(OutValid), .OutReady(OutReady),
        .Shifted(Shifted), .NormSumExpOut(NormSumExpOut), .Busy(Busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    // Number of clock edges after the accept edge before the result becomes visible.
    function automatic int exp_edges(input int amt);
`ifdef FMA_NORM_BARREL_EN
        return 0;
`else
        return (amt + STEP - 1) / STEP;
`endif
    endfunction

    function automatic logic [W-1:0] rand_data();
        logic [W-1:0] r = '0;
        for (int i = 0; i < W; i += 32) r = (r << 32) | W'($urandom);
        return r;
    endfunction

    // Transaction-level model: idle / waiting out a countdown / holding a result.
    bit            m_on = 0;
    int            m_phase = 0;
    int            m_wait = 0;
    logic [W-1:0]  m_data = '0;
    logic [TW-1:0] m_tag = '0;

    always @(posedge clk) begin
        if (reset) begin
            m_phase = 0;
            m_on = 1;
        end else if (Flush) begin
            m_phase = 0;
        end else begin
            case (m_phase)
                0: if (InValid) begin
                    m_data  = ShiftIn << ShiftAmt;
                    m_tag   = NormSumExpIn;
                    m_wait  = exp_edges(int'(ShiftAmt));
                    m_phase = (m_wait == 0) ? 2 : 1;
                end
                1: begin
                    m_wait--;
                    if (m_wait == 0) m_phase = 2;
                end
                default: if (OutReady) m_phase = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (m_on && !reset) begin
            chk("mon_inready",  W'(InReady),  W'(m_phase == 0));
            chk("mon_outvalid", W'(OutValid), W'(m_phase == 2));
            chk("mon_busy",     W'(Busy),     W'(m_phase != 0));
            chk("mon_shifted",  Shifted,      (m_phase == 2) ? m_data : '0);
            chk("mon_tag",      W'(NormSumExpOut), (m_phase == 2) ? W'(m_tag) : '0);
        end
    end

    task automatic run_req(input logic [W-1:0] d, input logic [SW-1:0] a, input logic [TW-1:0] t,
                           input logic [W-1:0] exp_d, input int exp_n, input string name, input bit at_neg);
        int  n = 0;
        bit  done = 0;
        if (!at_neg) @(negedge clk);
        InValid = 1'b1; ShiftIn = d; ShiftAmt = a; NormSumExpIn = t;
        chk({name, "_inready"}, W'(InReady), W'(1));
        @(posedge clk);
        #1 InValid = 1'b0;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk);
            if (OutValid) done = 1;
            else begin
                @(posedge clk);
                n++;
            end
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL %s_timeout got no OutValid expected OutValid within 100 cycles", name);
        end
        chk({name, "_latency"}, W'(n), W'(exp_n));
        chk({name, "_data"}, Shifted, exp_d);
        chk({name, "_tag"}, W'(NormSumExpOut), W'(t));
    endtask

    task automatic out_handshake();
        @(negedge clk);
        OutReady = 1'b1;
        @(posedge clk);
        #1 OutReady = 1'b0;
    endtask

    logic [W-1:0] one, ones, msb, rd;

    initial begin
        one  = W'(1);
        ones = '1;
        msb  = one << (W-1);

        // Reset
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_inready", W'(InReady), W'(1));
        chk("rst_outvalid", W'(OutValid), W'(0));
        chk("rst_busy", W'(Busy), W'(0));
        chk("rst_shifted", Shifted, '0);

        // Zero shift, multi-step shift with stalled consumer, overshift
        run_req(one, 8'd0, 13'h3FF, one, 0, "zero", 1);
        out_handshake();
        run_req(one, 8'd40, 13'h0AB, one << 40, exp_edges(40), "s40", 0);
`ifndef FMA_NORM_BARREL_EN
        chk("s40_lat_literal", W'(exp_edges(40)), W'(3));
`endif
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_data", Shifted, one << 40);
            chk("hold_valid", W'(OutValid), W'(1));
            chk("hold_inready", W'(InReady), W'(0));
        end
        out_handshake();
        run_req(ones, 8'd161, 13'h1234, msb, exp_edges(161), "s161", 0);
`ifndef FMA_NORM_BARREL_EN
        chk("s161_lat_literal", W'(exp_edges(161)), W'(11));
`endif
        out_handshake();
        run_req(ones, 8'd255, 13'h0042, '0, exp_edges(255), "s255", 0);
        out_handshake();

        // Flush in the second SHIFT cycle
        rd = rand_data();
        @(negedge clk);
        InValid = 1'b1; ShiftIn = rd; ShiftAmt = 8'd100; NormSumExpIn = 13'h0777;
        @(posedge clk);
        #1 InValid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        Flush = 1'b1;
        @(posedge clk);
        #1 Flush = 1'b0;
        @(negedge clk);
        chk("flush_outvalid", W'(OutValid), W'(0));
        chk("flush_inready", W'(InReady), W'(1));
        chk("flush_busy", W'(Busy), W'(0));
        chk("flush_shifted", Shifted, '0);
        run_req(one << 3, 8'd20, 13'h0155, one << 23, exp_edges(20), "post_flush", 1);
        out_handshake();

        // Back-to-back: second request accepted the cycle after the first handshake
        run_req(one, 8'd7, 13'h0011, one << 7, exp_edges(7), "b2b_a", 0);
        @(negedge clk);
        OutReady = 1'b1;
        InValid = 1'b1; ShiftIn = one; ShiftAmt = 8'd150; NormSumExpIn = 13'h0022;
        @(posedge clk);
        #1 OutReady = 1'b0;
        run_req(one, 8'd150, 13'h0022, one << 150, exp_edges(150), "b2b_b", 0);
        out_handshake();

        // Random traffic checked every cycle by the model
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            InValid      = ($urandom_range(0, 2) != 0);
            ShiftIn      = rand_data();
            ShiftAmt     = ($urandom_range(0, 3) == 0) ? SW'($urandom_range(0, 255)) : SW'($urandom_range(0, 40));
            NormSumExpIn = TW'($urandom);
            OutReady     = ($urandom_range(0, 1) == 1);
            Flush        = ($urandom_range(0, 39) == 0);
        end
        @(negedge clk);
        InValid = 1'b0; Flush = 1'b0; OutReady = 1'b1;
        repeat (20) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
